// File: rtl/prog_loader_if.sv
// prog_loader_if: host byte stream, memory write port and launch outputs.
// slave = loader side, master = host/chip side.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;
  logic        int_out;
  logic [31:0] entry_point;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_data, mem_write,
    output int_out, entry_point, busy, done, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_data, mem_write,
    input  int_out, entry_point, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: byte-stream image loader, writes words then raises INT.
// Define PROG_LOADER_CHECKSUM_EN to require a sum-of-words trailer.
module prog_loader #(
  parameter int INT_CYCLES = 2,
  parameter int ADDR_STEP  = 4,
  parameter int MAX_WORDS  = 65535
) (
  input  logic clk,
  input  logic rst_n,
  prog_loader_if.slave bus
);

  localparam logic [31:0] STEP  = 32'(ADDR_STEP);
  localparam logic [31:0] MAXW  = 32'(MAX_WORDS);
  localparam logic [31:0] ILAST = 32'(INT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HDR_ADDR,
    S_HDR_CNT,
    S_HDR_ENTRY,
    S_DATA,
    S_WRITE,
    S_LAUNCH,
    S_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_LAUNCH;
`endif

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [31:0] shreg, sh_n;
  logic [31:0] addr, addr_n;
  logic [31:0] rem, rem_n;
  logic [31:0] icnt, icnt_n;
  logic [31:0] word;
  logic        acc, last;
  logic        rdy_n, mwr_n, int_n;
  logic        busy_n, done_n, err_n;
  logic [31:0] maddr_n, mdata_n, ep_n;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum, sum_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_HDR_ADDR;
      idx             <= '0;
      shreg           <= '0;
      addr            <= '0;
      rem             <= '0;
      icnt            <= '0;
      bus.in_ready    <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_data    <= '0;
      bus.mem_write   <= 1'b0;
      bus.int_out     <= 1'b0;
      bus.entry_point <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum             <= '0;
`endif
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      shreg           <= sh_n;
      addr            <= addr_n;
      rem             <= rem_n;
      icnt            <= icnt_n;
      bus.in_ready    <= rdy_n;
      bus.mem_addr    <= maddr_n;
      bus.mem_data    <= mdata_n;
      bus.mem_write   <= mwr_n;
      bus.int_out     <= int_n;
      bus.entry_point <= ep_n;
      bus.busy        <= busy_n;
      bus.done        <= done_n;
      bus.err         <= err_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum             <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    sh_n    = shreg;
    addr_n  = addr;
    rem_n   = rem;
    maddr_n = bus.mem_addr;
    mdata_n = bus.mem_data;
    mwr_n   = 1'b0;
    ep_n    = bus.entry_point;
    done_n  = bus.done;
    err_n   = bus.err;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_n   = sum;
`endif
    word = {bus.in_data, shreg[31:8]};
    acc  = bus.in_valid && bus.in_ready;
    last = acc && (idx == 2'd3);
    if (acc) begin
      sh_n  = word;
      idx_n = idx + 2'd1;
      if (state == S_HDR_ADDR && idx == 2'd0)
        done_n = 1'b0;
    end
    unique case (state)
      S_HDR_ADDR:
        if (last) begin
          addr_n  = word;
          state_n = (word[1:0] != 2'b00) ? S_ERR : S_HDR_CNT;
        end
      S_HDR_CNT:
        if (last) begin
          rem_n   = word;
          state_n = (word > MAXW) ? S_ERR : S_HDR_ENTRY;
        end
      S_HDR_ENTRY:
        if (last) begin
          ep_n    = word;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_n   = '0;
`endif
          state_n = (rem == 32'd0) ? S_TAIL : S_DATA;
        end
      S_DATA:
        if (last) begin
          mwr_n   = 1'b1;
          maddr_n = addr;
          mdata_n = word;
          state_n = S_WRITE;
        end
      S_WRITE: begin
        addr_n  = addr + STEP;
        rem_n   = rem - 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_n   = sum + bus.mem_data;
`endif
        state_n = (rem == 32'd1) ? S_TAIL : S_DATA;
      end
      S_LAUNCH:
        if (icnt == ILAST) begin
          done_n  = 1'b1;
          state_n = S_HDR_ADDR;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:
        if (last)
          state_n = (word == sum) ? S_LAUNCH : S_ERR;
`endif
      S_ERR: ;
      default: state_n = S_ERR;
    endcase
    if (state_n == S_ERR) begin
      err_n  = 1'b1;
      done_n = 1'b0;
    end
    icnt_n = (state == S_LAUNCH) ? icnt + 32'd1 : 32'd0;
    int_n  = (state_n == S_LAUNCH);
    rdy_n  = (state_n == S_HDR_ADDR) || (state_n == S_HDR_CNT) ||
             (state_n == S_HDR_ENTRY) || (state_n == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
             || (state_n == S_CHK)
`endif
             ;
    busy_n = (state_n != S_ERR) &&
             !(state_n == S_HDR_ADDR && idx_n == 2'd0);
  end

endmodule
